// File: rtl/vga_pkg.sv
// Shared VGA 800x600@60 timing constants and types, used by both the timing
// generator and the monitor so the two ends of the interface cannot drift.
package vga_pkg;

    localparam int unsigned CNT_W = 11;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam int unsigned VGA_H_TOTAL      = 1056;
    localparam int unsigned VGA_H_ACTIVE     = 800;
    localparam int unsigned VGA_H_SYNC_START = 840;
    localparam int unsigned VGA_H_SYNC_WIDTH = 128;
    localparam int unsigned VGA_V_TOTAL      = 628;
    localparam int unsigned VGA_V_ACTIVE     = 600;
    localparam int unsigned VGA_V_SYNC_START = 601;
    localparam int unsigned VGA_V_SYNC_WIDTH = 4;

    // Field order gives err_mask bit positions: [0] hcount ... [5] vblnk.
    typedef struct packed {
        logic vblnk;
        logic hblnk;
        logic vsync;
        logic hsync;
        logic vcount;
        logic hcount;
    } err_mask_t;

endpackage

// File: rtl/vga_expected_counter.sv
// Free-running VGA position counter with loadable start point; derives the
// sync/blank levels for the current position from half-open ranges.
module vga_expected_counter
    import vga_pkg::*;
#(
    parameter int unsigned H_TOTAL      = VGA_H_TOTAL,
    parameter int unsigned H_ACTIVE     = VGA_H_ACTIVE,
    parameter int unsigned H_SYNC_START = VGA_H_SYNC_START,
    parameter int unsigned H_SYNC_WIDTH = VGA_H_SYNC_WIDTH,
    parameter int unsigned V_TOTAL      = VGA_V_TOTAL,
    parameter int unsigned V_ACTIVE     = VGA_V_ACTIVE,
    parameter int unsigned V_SYNC_START = VGA_V_SYNC_START,
    parameter int unsigned V_SYNC_WIDTH = VGA_V_SYNC_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_hcount,
    input  logic [CNT_W-1:0] load_vcount,
    input  logic             enable,
    output logic [CNT_W-1:0] exp_hcount,
    output logic [CNT_W-1:0] exp_vcount,
    output logic             exp_hsync,
    output logic             exp_vsync,
    output logic             exp_hblnk,
    output logic             exp_vblnk
);

    localparam cnt_t H_LAST   = cnt_t'(H_TOTAL - 1);
    localparam cnt_t V_LAST   = cnt_t'(V_TOTAL - 1);
    localparam cnt_t H_ACT    = cnt_t'(H_ACTIVE);
    localparam cnt_t V_ACT    = cnt_t'(V_ACTIVE);
    localparam cnt_t HS_START = cnt_t'(H_SYNC_START);
    localparam cnt_t HS_END   = cnt_t'(H_SYNC_START + H_SYNC_WIDTH);
    localparam cnt_t VS_START = cnt_t'(V_SYNC_START);
    localparam cnt_t VS_END   = cnt_t'(V_SYNC_START + V_SYNC_WIDTH);

    cnt_t hcount_q, hcount_d;
    cnt_t vcount_q, vcount_d;

    always_comb begin
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (load) begin
            hcount_d = load_hcount;
            vcount_d = load_vcount;
        end else if (enable) begin
            if (hcount_q == H_LAST) begin
                hcount_d = '0;
                vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 1'b1;
            end else begin
                hcount_d = hcount_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_q <= '0;
            vcount_q <= '0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
        end
    end

    assign exp_hcount = hcount_q;
    assign exp_vcount = vcount_q;
    assign exp_hsync  = (hcount_q >= HS_START) && (hcount_q < HS_END);
    assign exp_vsync  = (vcount_q >= VS_START) && (vcount_q < VS_END);
    assign exp_hblnk  = (hcount_q >= H_ACT);
    assign exp_vblnk  = (vcount_q >= V_ACT);

endmodule

// File: rtl/vga_timing_monitor.sv
// Passive checker for the VGA timing bus: locks on a vsync rising edge, then
// tracks its own expected position and flags any divergence of the six signals.
module vga_timing_monitor
    import vga_pkg::*;
#(
    parameter int unsigned H_TOTAL      = VGA_H_TOTAL,
    parameter int unsigned H_ACTIVE     = VGA_H_ACTIVE,
    parameter int unsigned H_SYNC_START = VGA_H_SYNC_START,
    parameter int unsigned H_SYNC_WIDTH = VGA_H_SYNC_WIDTH,
    parameter int unsigned V_TOTAL      = VGA_V_TOTAL,
    parameter int unsigned V_ACTIVE     = VGA_V_ACTIVE,
    parameter int unsigned V_SYNC_START = VGA_V_SYNC_START,
    parameter int unsigned V_SYNC_WIDTH = VGA_V_SYNC_WIDTH,
    parameter int unsigned LOCK_FRAMES  = 2
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic [CNT_W-1:0] hcount,
    input  logic [CNT_W-1:0] vcount,
    input  logic             hsync,
    input  logic             vsync,
    input  logic             hblnk,
    input  logic             vblnk,
    output logic             locked,
    output logic             err_pulse,
    output logic [5:0]       err_mask,
    output logic [CNT_W-1:0] err_hcount,
    output logic [CNT_W-1:0] err_vcount,
    output logic [15:0]      frame_cnt,
    output logic [7:0]       err_cnt
);

    typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

    localparam cnt_t       H_LAST = cnt_t'(H_TOTAL - 1);
    localparam cnt_t       V_LAST = cnt_t'(V_TOTAL - 1);
    localparam cnt_t       V_LOAD = cnt_t'(V_SYNC_START);
    localparam logic [7:0] LOCK_N = 8'(LOCK_FRAMES);

    state_t     state_q, state_d;
    cnt_t       s1_hcount_q, s1_vcount_q;
    logic       s1_hsync_q, s1_vsync_q, s1_hblnk_q, s1_vblnk_q;
    logic       vsync_q;
    logic [7:0] clean_q, clean_d;
    logic       locked_q, locked_d;
    logic       err_pulse_q, err_pulse_d;
    err_mask_t  err_mask_q, err_mask_d;
    cnt_t       err_hcount_q, err_hcount_d;
    cnt_t       err_vcount_q, err_vcount_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [7:0] err_cnt_q, err_cnt_d;

    logic       load, enable;
    cnt_t       exp_hcount, exp_vcount;
    logic       exp_hsync, exp_vsync, exp_hblnk, exp_vblnk;
    err_mask_t  cmp;
    logic       mismatch, boundary, vsync_rise;

    // Loaded with the position the sample after the vsync edge must carry.
    vga_expected_counter #(
        .H_TOTAL     (H_TOTAL),
        .H_ACTIVE    (H_ACTIVE),
        .H_SYNC_START(H_SYNC_START),
        .H_SYNC_WIDTH(H_SYNC_WIDTH),
        .V_TOTAL     (V_TOTAL),
        .V_ACTIVE    (V_ACTIVE),
        .V_SYNC_START(V_SYNC_START),
        .V_SYNC_WIDTH(V_SYNC_WIDTH)
    ) u_exp (
        .clk        (pclk),
        .rst        (rst),
        .load       (load),
        .load_hcount(cnt_t'(1)),
        .load_vcount(V_LOAD),
        .enable     (enable),
        .exp_hcount (exp_hcount),
        .exp_vcount (exp_vcount),
        .exp_hsync  (exp_hsync),
        .exp_vsync  (exp_vsync),
        .exp_hblnk  (exp_hblnk),
        .exp_vblnk  (exp_vblnk)
    );

    always_comb begin
        cmp.hcount = (s1_hcount_q != exp_hcount);
        cmp.vcount = (s1_vcount_q != exp_vcount);
        cmp.hsync  = (s1_hsync_q  != exp_hsync);
        cmp.vsync  = (s1_vsync_q  != exp_vsync);
        cmp.hblnk  = (s1_hblnk_q  != exp_hblnk);
        cmp.vblnk  = (s1_vblnk_q  != exp_vblnk);
        mismatch   = (cmp != '0);
        boundary   = (exp_hcount == H_LAST) && (exp_vcount == V_LAST);
        vsync_rise = s1_vsync_q && !vsync_q;
    end

    always_comb begin
        state_d      = state_q;
        clean_d      = clean_q;
        load         = 1'b0;
        enable       = 1'b0;
        err_pulse_d  = 1'b0;
        err_mask_d   = err_mask_q;
        err_hcount_d = err_hcount_q;
        err_vcount_d = err_vcount_q;
        frame_cnt_d  = frame_cnt_q;
        err_cnt_d    = err_cnt_q;
        case (state_q)
            SEARCH: begin
                if (vsync_rise) begin
                    load    = 1'b1;
                    clean_d = '0;
                    state_d = TRACK;
                end
            end
            TRACK, LOCKED: begin
                enable = 1'b1;
                // An error on a boundary sample suppresses that boundary's count.
                if (mismatch) begin
                    err_pulse_d  = 1'b1;
                    err_mask_d   = cmp;
                    err_hcount_d = exp_hcount;
                    err_vcount_d = exp_vcount;
                    if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
                    state_d = SEARCH;
                end else if (boundary) begin
                    if (state_q == TRACK) begin
                        clean_d = clean_q + 8'd1;
                        if (clean_d >= LOCK_N) state_d = LOCKED;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 16'd1;
                    end
                end
            end
            default: state_d = SEARCH;
        endcase
        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            s1_hcount_q  <= '0;
            s1_vcount_q  <= '0;
            s1_hsync_q   <= 1'b0;
            s1_vsync_q   <= 1'b0;
            s1_hblnk_q   <= 1'b0;
            s1_vblnk_q   <= 1'b0;
            vsync_q      <= 1'b0;
            state_q      <= SEARCH;
            clean_q      <= '0;
            locked_q     <= 1'b0;
            err_pulse_q  <= 1'b0;
            err_mask_q   <= '0;
            err_hcount_q <= '0;
            err_vcount_q <= '0;
            frame_cnt_q  <= '0;
            err_cnt_q    <= '0;
        end else begin
            s1_hcount_q  <= hcount;
            s1_vcount_q  <= vcount;
            s1_hsync_q   <= hsync;
            s1_vsync_q   <= vsync;
            s1_hblnk_q   <= hblnk;
            s1_vblnk_q   <= vblnk;
            vsync_q      <= s1_vsync_q;
            state_q      <= state_d;
            clean_q      <= clean_d;
            locked_q     <= locked_d;
            err_pulse_q  <= err_pulse_d;
            err_mask_q   <= err_mask_d;
            err_hcount_q <= err_hcount_d;
            err_vcount_q <= err_vcount_d;
            frame_cnt_q  <= frame_cnt_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign locked     = locked_q;
    assign err_pulse  = err_pulse_q;
    assign err_mask   = err_mask_q;
    assign err_hcount = err_hcount_q;
    assign err_vcount = err_vcount_q;
    assign frame_cnt  = frame_cnt_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Directed bench for vga_timing_monitor on a shrunken 20x12 frame; expected
// outputs are queued per driven sample and checked two cycles later.
module tb_vga_timing_monitor;

    localparam int HT = 20, HA = 14, HSS = 15, HSW = 3;
    localparam int VT = 12, VA = 8, VSS = 9, VSW = 2;
    localparam int LF = 2;

    logic        pclk = 1'b0;
    logic        rst;
    logic [10:0] hcount, vcount;
    logic        hsync, vsync, hblnk, vblnk;
    logic        locked, err_pulse;
    logic [5:0]  err_mask;
    logic [10:0] err_hcount, err_vcount;
    logic [15:0] frame_cnt;
    logic [7:0]  err_cnt;

    vga_timing_monitor #(
        .H_TOTAL(HT), .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_WIDTH(HSW),
        .V_TOTAL(VT), .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_WIDTH(VSW),
        .LOCK_FRAMES(LF)
    ) dut (
        .pclk(pclk), .rst(rst),
        .hcount(hcount), .vcount(vcount), .hsync(hsync), .vsync(vsync),
        .hblnk(hblnk), .vblnk(vblnk),
        .locked(locked), .err_pulse(err_pulse), .err_mask(err_mask),
        .err_hcount(err_hcount), .err_vcount(err_vcount),
        .frame_cnt(frame_cnt), .err_cnt(err_cnt)
    );

    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        string       tag;
        logic        err;
        logic        lck;
        bit          full;
        logic [5:0]  mask;
        logic [10:0] eh, ev;
        logic [15:0] fc;
        logic [7:0]  ec;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   n_cmp = 0, n_fail = 0;
    bit   done = 1'b0, drained = 1'b0;
    int   done_cyc = 0;

    // Expectations attached to the next driven sample.
    string       x_tag = "reset";
    logic        x_err = 1'b0, x_lck = 1'b0;
    bit          x_full = 1'b0;
    logic [5:0]  x_mask = '0;
    logic [10:0] x_eh = '0, x_ev = '0;
    logic [15:0] x_fc = '0;
    logic [7:0]  x_ec = '0;

    int gen_h = 0, gen_v = 0;

    task automatic expect_full(input string tag, input logic [5:0] m, input int eh, input int ev,
                               input int fc, input int ec);
        x_tag  = tag;
        x_full = 1'b1;
        x_mask = m;
        x_eh   = 11'(eh);
        x_ev   = 11'(ev);
        x_fc   = 16'(fc);
        x_ec   = 8'(ec);
    endtask

    task automatic drive_raw(input logic [10:0] h, input logic [10:0] v,
                             input logic hs, input logic vs, input logic hb, input logic vb);
        exp_t e;
        hcount = h; vcount = v; hsync = hs; vsync = vs; hblnk = hb; vblnk = vb;
        e.due = cyc + 2; e.tag = x_tag; e.err = x_err; e.lck = x_lck; e.full = x_full;
        e.mask = x_mask; e.eh = x_eh; e.ev = x_ev; e.fc = x_fc; e.ec = x_ec;
        sb.push_back(e);
        x_full = 1'b0;
        @(posedge pclk);
        #1;
    endtask

    task automatic gen_advance();
        gen_h++;
        if (gen_h == HT) begin
            gen_h = 0;
            gen_v = (gen_v == VT - 1) ? 0 : gen_v + 1;
        end
    endtask

    task automatic gen_step();
        drive_raw(11'(gen_h), 11'(gen_v),
                  (gen_h >= HSS) && (gen_h < HSS + HSW), (gen_v >= VSS) && (gen_v < VSS + VSW),
                  gen_h >= HA, gen_v >= VA);
        gen_advance();
    endtask

    task automatic run(input int n);
        repeat (n) gen_step();
    endtask

    task automatic run_to(input int h, input int v);
        for (int i = 0; i < HT * VT && !(gen_h == h && gen_v == v); i++) gen_step();
    endtask

    // Monitor: pops every entry whose due cycle has arrived.
    always @(negedge pclk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            m_e = sb.pop_front();
            n_cmp++;
            assert (err_pulse === m_e.err) else begin
                n_fail++;
                $error("FAIL %s/err_pulse @%0d observed=%b expected=%b", m_e.tag, cyc, err_pulse, m_e.err);
            end
            n_cmp++;
            assert (locked === m_e.lck) else begin
                n_fail++;
                $error("FAIL %s/locked @%0d observed=%b expected=%b", m_e.tag, cyc, locked, m_e.lck);
            end
            if (m_e.full) begin
                n_cmp++;
                assert (err_mask === m_e.mask) else begin
                    n_fail++;
                    $error("FAIL %s/err_mask observed=%b expected=%b", m_e.tag, err_mask, m_e.mask);
                end
                n_cmp++;
                assert (err_hcount === m_e.eh) else begin
                    n_fail++;
                    $error("FAIL %s/err_hcount observed=%0d expected=%0d", m_e.tag, err_hcount, m_e.eh);
                end
                n_cmp++;
                assert (err_vcount === m_e.ev) else begin
                    n_fail++;
                    $error("FAIL %s/err_vcount observed=%0d expected=%0d", m_e.tag, err_vcount, m_e.ev);
                end
                n_cmp++;
                assert (frame_cnt === m_e.fc) else begin
                    n_fail++;
                    $error("FAIL %s/frame_cnt observed=%0d expected=%0d", m_e.tag, frame_cnt, m_e.fc);
                end
                n_cmp++;
                assert (err_cnt === m_e.ec) else begin
                    n_fail++;
                    $error("FAIL %s/err_cnt observed=%0d expected=%0d", m_e.tag, err_cnt, m_e.ec);
                end
            end
        end
        if (done && !drained && cyc >= done_cyc + 3) begin
            drained = 1'b1;
            n_cmp++;
            assert (sb.size() == 0) else begin
                n_fail++;
                $error("FAIL drain pending=%0d expected=0", sb.size());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        // Reset with random inputs: everything stays zero.
        rst = 1'b1;
        repeat (4) drive_raw(11'($urandom), 11'($urandom), 1'($urandom), 1'($urandom),
                             1'($urandom), 1'($urandom));
        expect_full("reset", 6'b0, 0, 0, 0, 0);
        drive_raw(11'($urandom), 11'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        rst = 1'b0;

        // Clean stream: search, rise at (0,9), lock on 2nd boundary (299 samples later).
        x_tag = "search";
        run_to(0, VSS);
        x_tag = "track";
        run(299);
        x_lck = 1'b1;
        expect_full("lock", 6'b0, 0, 0, 0, 0);
        gen_step();
        x_tag = "locked";
        run(239);
        expect_full("frame1", 6'b0, 0, 0, 1, 0);
        gen_step();

        // hsync dropped at expected (16,3).
        run_to(16, 3);
        x_err = 1'b1; x_lck = 1'b0;
        expect_full("hsync_err", 6'b000100, 16, 3, 1, 1);
        drive_raw(11'd16, 11'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        gen_advance();
        x_err = 1'b0; x_tag = "hsync_relock";
        run_to(0, VSS);
        run(299);
        x_lck = 1'b1;
        expect_full("hsync_relock", 6'b000100, 16, 3, 1, 1);
        gen_step();

        // Generator skips hcount 11 on line 2.
        run_to(10, 2);
        gen_step();
        gen_h = 12;
        x_err = 1'b1; x_lck = 1'b0;
        expect_full("skip_err", 6'b000001, 11, 2, 1, 2);
        gen_step();
        x_err = 1'b0; x_tag = "skip_search";
        run_to(0, VSS);
        run(299);
        x_lck = 1'b1;
        expect_full("skip_relock", 6'b000001, 11, 2, 1, 2);
        gen_step();

        // Reset while locked at (5,4): outputs clear one cycle after rst is sampled.
        run_to(4, 4);
        x_lck = 1'b0;
        expect_full("rst_locked", 6'b0, 0, 0, 0, 0);
        gen_step();
        rst = 1'b1;
        expect_full("rst_hold", 6'b0, 0, 0, 0, 0);
        gen_step();
        rst = 1'b0;
        x_tag = "rst_search";
        run_to(0, VSS);
        run(299);
        x_lck = 1'b1;
        expect_full("rst_relock", 6'b0, 0, 0, 0, 0);
        gen_step();
        run(239);
        expect_full("rst_frame1", 6'b0, 0, 0, 1, 0);
        gen_step();

        // Error on a boundary sample, then 299 rise/garbage pairs to saturate err_cnt.
        run_to(HT - 1, VT - 1);
        x_err = 1'b1; x_lck = 1'b0;
        expect_full("bound_err", 6'b100000, HT - 1, VT - 1, 1, 1);
        drive_raw(11'(HT - 1), 11'(VT - 1), 1'b0, 1'b0, 1'b1, 1'b0);
        gen_advance();
        x_tag = "sat";
        for (int i = 0; i < 299; i++) begin
            x_err = 1'b0;
            drive_raw(11'd0, 11'(VSS), 1'b0, 1'b1, 1'b0, 1'b1);
            x_err = 1'b1;
            if (i == 252) expect_full("sat254", 6'b101011, 1, VSS, 1, 254);
            if (i == 253) expect_full("sat255", 6'b101011, 1, VSS, 1, 255);
            if (i == 298) expect_full("sat300", 6'b101011, 1, VSS, 1, 255);
            drive_raw(11'd2047, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        x_err = 1'b0; x_tag = "tail";
        run(3);

        done_cyc = cyc;
        done = 1'b1;
        repeat (6) @(negedge pclk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_monitor.md
Name: vga_timing_monitor

Overview:
- Passive checker on the output bus of the VGA timing generator: hcount, vcount, hsync, vsync, hblnk, vblnk.
- Locks to the incoming frame on a vsync rising edge, then runs its own expected position counters and compares all six signals every pclk.
- Reports lock status, per-signal mismatch flags, and frame and error counts.
- Sits beside the generator in simulation and on-chip debug, as the receiving end of the timing interface.

Parameters:
- H_TOTAL, 1056, pixels per line
- H_ACTIVE, 800, visible pixels; hblnk=1 for hcount>=H_ACTIVE
- H_SYNC_START, 840, first hcount with hsync=1
- H_SYNC_WIDTH, 128, hsync high length in pixels
- V_TOTAL, 628, lines per frame
- V_ACTIVE, 600, visible lines; vblnk=1 for vcount>=V_ACTIVE
- V_SYNC_START, 601, first vcount with vsync=1
- V_SYNC_WIDTH, 4, vsync high length in lines
- LOCK_FRAMES, 2, clean frame boundaries needed before locked=1

Ports:
- pclk  in  1  pixel clock (40 MHz)
- rst  in  1  synchronous reset, active-high
- hcount  in  11  observed horizontal position
- vcount  in  11  observed vertical position
- hsync  in  1  observed hsync, positive polarity
- vsync  in  1  observed vsync, positive polarity
- hblnk  in  1  observed horizontal blank
- vblnk  in  1  observed vertical blank
- locked  out  1  stream matched for LOCK_FRAMES boundaries
- err_pulse  out  1  one-cycle pulse on any mismatch while not in SEARCH
- err_mask  out  6  bits of last error: [0]hcount [1]vcount [2]hsync [3]vsync [4]hblnk [5]vblnk
- err_hcount  out  11  expected hcount at last error
- err_vcount  out  11  expected vcount at last error
- frame_cnt  out  16  completed LOCKED frames; wraps at 65535->0
- err_cnt  out  8  errors since reset; saturates at 255

Behaviour:
- Interface: one clock, pclk. Reset rst is synchronous and active-high.
- All inputs are registered once (stage S1). Comparisons use S1 values. Outputs are registered, giving 2 pclk total latency from input to err_pulse.
- Reset values: all outputs 0, FSM in SEARCH, vsync_q=0, expected counters 0.
- Reset has priority over every event. Asserting rst mid-frame returns to SEARCH on the next edge.
- SEARCH: compares nothing.
  - On S1 vsync=1 and vsync_q=0, load expected = (hcount 1, vcount V_SYNC_START) for the next sample.
  - Clear clean_frames; go to TRACK.
- Expected counters advance every cycle in TRACK/LOCKED:
  - h wraps H_TOTAL-1 -> 0.
  - v increments on the h wrap and wraps V_TOTAL-1 -> 0.
- Expected sync and blank values are derived combinationally from the expected counters using half-open ranges [START, START+WIDTH).
- mismatch = OR of the six per-signal compares.
- TRACK:
  - Mismatch: err_pulse, update err_mask/err_hcount/err_vcount, err_cnt++, go to SEARCH.
  - Clean sample at expected (H_TOTAL-1, V_TOTAL-1): clean_frames++. The first partial frame counts.
  - clean_frames reaching LOCK_FRAMES: go to LOCKED; locked=1 on the following cycle.
- LOCKED:
  - Same error handling as TRACK. On error, locked drops to 0 in the same cycle err_pulse rises.
  - Clean boundary sample: frame_cnt++.
- A vsync edge seen while in TRACK/LOCKED is only compared; it never reloads the counters.
- A mismatch on the same cycle as a boundary: the error wins, and neither the frame counter nor clean_frames increments.
- Counter width: 11 bits covers H_TOTAL and V_TOTAL up to 2047. Values at or above 2048 are outside the parameter range.

Decomposition:
- Timing constants (H_/V_ totals, active, sync start/width) live in the shared vga_pkg used by the generator, so both ends cannot drift.
- The FSM state enum (SEARCH, TRACK, LOCKED) is a local typedef.
- Sub-module vga_expected_counter:
  - Inputs: load, load values, enable.
  - Outputs: expected hcount/vcount and the four derived sync/blank bits.
  - Reusable by the generator itself.

Test Plan:
- rst held 5 cycles with random inputs -> all outputs 0; err_pulse never asserts in SEARCH.
- Clean generator stream, first vsync rise sampled at (0,601):
  - locked=1 exactly 28511+663168 = 691679 pclk after that sample, plus 2-cycle latency.
  - err_cnt stays 0.
  - frame_cnt=1 one frame later.
- Locked stream, force hsync=0 at expected (900,10):
  - err_pulse once; err_mask=6'b000100; err_hcount=900; err_vcount=10; locked=0; err_cnt=1.
  - Relocks after LOCK_FRAMES boundaries.
- Locked stream, generator skips one hcount (999 -> 1001):
  - err_mask bit0 set; return to SEARCH; no further err_pulse until the next vsync rise.
- Assert rst during LOCKED at (500,300) -> next cycle locked=0 and counts 0; relock on the next vsync edge.
- Inject 300 errors -> err_cnt saturates at 255; frame_cnt unaffected.
